uart_alu_pkt_parser: RTL and testbench

//  Frames the UART byte stream for the ALU. Sits between uart_rx (AXIS bytes) and the ALU/echo datapath.

---
 rtl/uart_alu_pkg.sv | 31 +++
 rtl/uart_alu_pkt_parser_if.sv | 32 +++
 rtl/uart_alu_idle_timer.sv | 31 +++
 rtl/uart_alu_pkt_parser.sv | 167 ++++++++++++++++
 tb/tb_uart_alu_pkt_parser.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_alu_pkg.sv
// Purpose : shared opcode / state definitions for the UART ALU datapath
//           (parser, ALU and tx framer all import this package).
// Contents: HDR_BYTES, opcode_e, parser_state_e, is_legal_op().
package uart_alu_pkg;

    localparam int HDR_BYTES = 4;

    typedef enum logic [7:0] {
        OP_ECHO = 8'hEC,
        OP_ADD  = 8'hAD,
        OP_MUL  = 8'h88,
        OP_DIV  = 8'h99
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSVD,
        ST_LEN_L,
        ST_LEN_H,
        ST_PAYLOAD,
        ST_DRAIN
    } parser_state_e;

    function automatic logic is_legal_op(input logic [7:0] op);
        case (op)
            OP_ECHO, OP_ADD, OP_MUL, OP_DIV: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_pkt_parser_if.sv
// Purpose : byte-stream handshake bundle around uart_alu_pkt_parser.
// Signals : s_axis_* (bytes in from uart_rx), m_axis_* (payload out to ALU),
//           opcode_o / payload_len_o / hdr_valid_o / err_o (header status).
// Modports: slave  = parser side, master = environment side.
interface uart_alu_pkt_parser_if;
    import uart_alu_pkg::*;

    logic [7:0]  s_axis_tdata_i;
    logic        s_axis_tvalid_i;
    logic        s_axis_tready_o;
    logic [7:0]  m_axis_tdata_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i;
    logic        m_axis_tlast_o;
    logic [7:0]  opcode_o;
    logic [15:0] payload_len_o;
    logic        hdr_valid_o;
    logic        err_o;

    modport slave (
        input  s_axis_tdata_i, s_axis_tvalid_i, m_axis_tready_i,
        output s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o,
        output opcode_o, payload_len_o, hdr_valid_o, err_o
    );

    modport master (
        output s_axis_tdata_i, s_axis_tvalid_i, m_axis_tready_i,
        input  s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o,
        input  opcode_o, payload_len_o, hdr_valid_o, err_o
    );

endinterface

// File: rtl/uart_alu_idle_timer.sv
// Purpose : idle-gap down-counter. Reloads to TIMEOUT_CYCLES on clear,
//           counts down while enabled, pulses expire on the TIMEOUT_CYCLES-th
//           enabled cycle without a clear.
// Ports   : i_clk, i_reset (sync, active-high), i_clear, i_count_en, o_expire.
module uart_alu_idle_timer #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expire
);

    localparam logic [31:0] LOAD_VAL = 32'(TIMEOUT_CYCLES);

    logic [31:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= LOAD_VAL;
        end else if (i_clear) begin
            r_count <= LOAD_VAL;
        end else if (i_count_en) begin
            r_count <= (r_count == 32'd1) ? LOAD_VAL : r_count - 32'd1;
        end
    end

    assign o_expire = i_count_en && !i_clear && (r_count == 32'd1);

endmodule

// File: rtl/uart_alu_pkt_parser.sv
// Purpose : frames the uart_rx byte stream for the ALU. Consumes the 4-byte
//           header {opcode, reserved, len_lsb, len_msb}, publishes opcode and
//           payload length, forwards payload bytes with tlast; drains and flags
//           unknown opcodes, flags illegal lengths.
// Ports   : clk_i, reset_i (sync, active-high), bus (uart_alu_pkt_parser_if.slave).
// Config  : UART_ALU_PARSER_TIMEOUT_EN enables the idle-gap abort
//           (TIMEOUT_CYCLES); without it the parser waits indefinitely.
module uart_alu_pkt_parser #(
    parameter logic [15:0] MAX_LEN        = 16'd1024,
    parameter int          TIMEOUT_CYCLES = 200000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    uart_alu_pkt_parser_if.slave  bus
);
    import uart_alu_pkg::*;

    localparam logic [15:0] HDR_LEN = 16'(HDR_BYTES);

    parser_state_e r_state, w_state_nxt;
    logic [7:0]  r_op;
    logic [7:0]  r_len_l;
    logic [15:0] r_remaining, w_remaining_nxt;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic        r_out_last;
    logic [7:0]  r_opcode;
    logic [15:0] r_payload_len;
    logic        r_hdr_valid;
    logic        r_err;

    logic        w_tready;
    logic        w_accept;
    logic [15:0] w_len;
    logic        w_hdr_pulse;
    logic        w_err_pulse;
    logic        w_load_out;
    logic        w_out_last_nxt;
    logic        w_timeout;

    // Header bytes never touch the output register, so only PAYLOAD is
    // throttled by it; this lets the next header flow in while the final
    // beat of the previous packet still waits on m_axis.
    assign w_tready = !reset_i &&
                      ((r_state != ST_PAYLOAD) || !r_out_valid || bus.m_axis_tready_i);
    assign w_accept = bus.s_axis_tvalid_i && w_tready;
    assign w_len    = {bus.s_axis_tdata_i, r_len_l};

`ifdef UART_ALU_PARSER_TIMEOUT_EN
    uart_alu_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .i_clk      (clk_i),
        .i_reset    (reset_i),
        .i_clear    (w_accept || (r_state == ST_IDLE)),
        .i_count_en (r_state != ST_IDLE),
        .o_expire   (w_timeout)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_hdr_pulse     = 1'b0;
        w_err_pulse     = 1'b0;
        w_load_out      = 1'b0;
        w_out_last_nxt  = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_RSVD;
            ST_RSVD:  if (w_accept) w_state_nxt = ST_LEN_L;
            ST_LEN_L: if (w_accept) w_state_nxt = ST_LEN_H;
            ST_LEN_H: begin
                if (w_accept) begin
                    if ((w_len < HDR_LEN) || (w_len > MAX_LEN)) begin
                        // No drain: length is untrustworthy, resync on next byte.
                        w_err_pulse = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_remaining_nxt = w_len - HDR_LEN;
                        w_hdr_pulse     = is_legal_op(r_op);
                        w_err_pulse     = !is_legal_op(r_op);
                        if (w_len == HDR_LEN)
                            w_state_nxt = ST_IDLE;
                        else
                            w_state_nxt = is_legal_op(r_op) ? ST_PAYLOAD : ST_DRAIN;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    w_load_out     = 1'b1;
                    w_out_last_nxt = (r_remaining == 16'd1);
                    if (r_remaining == 16'd1)
                        w_state_nxt = ST_IDLE;
                    else
                        w_remaining_nxt = r_remaining - 16'd1;
                end
            end
            ST_DRAIN: begin
                if (w_accept) begin
                    if (r_remaining == 16'd1)
                        w_state_nxt = ST_IDLE;
                    else
                        w_remaining_nxt = r_remaining - 16'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Expiry only fires on a cycle with no accepted byte, so it never
        // coincides with a header result.
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_err_pulse = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state       <= ST_IDLE;
            r_op          <= 8'd0;
            r_len_l       <= 8'd0;
            r_remaining   <= 16'd0;
            r_out_data    <= 8'd0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_opcode      <= 8'd0;
            r_payload_len <= 16'd0;
            r_hdr_valid   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_hdr_valid <= w_hdr_pulse;
            r_err       <= w_err_pulse;
            if ((r_state == ST_IDLE) && w_accept)
                r_op <= bus.s_axis_tdata_i;
            if ((r_state == ST_LEN_L) && w_accept)
                r_len_l <= bus.s_axis_tdata_i;
            if (w_hdr_pulse) begin
                r_opcode      <= r_op;
                r_payload_len <= w_len - HDR_LEN;
            end
            if (w_load_out) begin
                r_out_data  <= bus.s_axis_tdata_i;
                r_out_valid <= 1'b1;
                r_out_last  <= w_out_last_nxt;
            end else if (bus.m_axis_tready_i) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.s_axis_tready_o = w_tready;
    assign bus.m_axis_tdata_o  = r_out_data;
    assign bus.m_axis_tvalid_o = r_out_valid;
    assign bus.m_axis_tlast_o  = r_out_last;
    assign bus.opcode_o        = r_opcode;
    assign bus.payload_len_o   = r_payload_len;
    assign bus.hdr_valid_o     = r_hdr_valid;
    assign bus.err_o           = r_err;

endmodule

// File: tb/tb_uart_alu_pkt_parser.sv
module tb_uart_alu_pkt_parser;

    localparam int MAXL = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_alu_pkt_parser_if u_if();

    uart_alu_pkt_parser #(
        .MAX_LEN        (16'd1024),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (u_if)
    );

    int tests = 0;
    int fails = 0;
    int rdy_mode = 0;
    bit gaps = 0;
    bit mon_en = 0;

    logic [7:0]  q_data[$];
    bit          q_last[$];
    logic [23:0] q_hdr[$];
    int got_hdr, got_err, got_beats;

    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    typedef struct {
        logic [127:0] b;
        int           n;
        int           mode;
        int           hdrs;
        int           errs;
        int           beats;
        logic [7:0]   op;
        logic [15:0]  plen;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(u_if.m_axis_tvalid_o), 32'd1);
                check("hold_data",  32'(u_if.m_axis_tdata_o), 32'(prev_data));
                check("hold_last",  32'(u_if.m_axis_tlast_o), 32'(prev_last));
            end
            if (u_if.m_axis_tvalid_o && u_if.m_axis_tready_i) begin
                got_beats++;
                if (q_data.size() == 0)
                    check("extra_beat", 32'(q_data.size()), 32'd1);
                else begin
                    check("beat_data", 32'(u_if.m_axis_tdata_o), 32'(q_data.pop_front()));
                    check("beat_last", 32'(u_if.m_axis_tlast_o), 32'(q_last.pop_front()));
                end
            end
            if (u_if.hdr_valid_o) begin
                got_hdr++;
                if (q_hdr.size() == 0)
                    check("extra_hdr", 32'(q_hdr.size()), 32'd1);
                else
                    check("hdr_fields", 32'({u_if.opcode_o, u_if.payload_len_o}), 32'(q_hdr.pop_front()));
            end
            if (u_if.err_o) got_err++;
            if (u_if.hdr_valid_o || u_if.err_o)
                check("hdr_err_excl", 32'(u_if.hdr_valid_o && u_if.err_o), 32'd0);
            prev_stall = u_if.m_axis_tvalid_o && !u_if.m_axis_tready_i;
            prev_data  = u_if.m_axis_tdata_o;
            prev_last  = u_if.m_axis_tlast_o;
        end else begin
            prev_stall = 0;
        end
    end

    // Downstream ready pattern.
    initial begin
        u_if.m_axis_tready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       u_if.m_axis_tready_i = 1'b1;
                1:       u_if.m_axis_tready_i = ~u_if.m_axis_tready_i;
                2:       u_if.m_axis_tready_i = ($urandom_range(0, 2) != 0);
                default: u_if.m_axis_tready_i = 1'b0;
            endcase
        end
    end

    // Packet-level reference: walk the stream header by header.
    task automatic model(input logic [7:0] s[$], output int nh, output int ne);
        int i;
        int n;
        int len;
        logic [7:0] op;
        i = 0;
        n = s.size();
        nh = 0;
        ne = 0;
        while (i + 4 <= n) begin
            op  = s[i];
            len = int'(s[i+2]) + 256 * int'(s[i+3]);
            i += 4;
            if (len < 4 || len > MAXL) begin
                ne++;
            end else if (!(op inside {8'hEC, 8'hAD, 8'h88, 8'h99})) begin
                ne++;
                i += len - 4;
            end else begin
                nh++;
                q_hdr.push_back({op, 16'(len - 4)});
                for (int k = 0; k < len - 4; k++) begin
                    q_data.push_back(s[i+k]);
                    q_last.push_back(k == len - 5);
                end
                i += len - 4;
            end
        end
    endtask

    task automatic send(input logic [7:0] s[$]);
        int idx;
        int guard;
        bit acc;
        idx = 0;
        guard = 0;
        while (idx < s.size() && guard < 20000) begin
            u_if.s_axis_tvalid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            u_if.s_axis_tdata_i  = s[idx];
            @(negedge clk);
            acc = u_if.s_axis_tvalid_i && u_if.s_axis_tready_o;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        u_if.s_axis_tvalid_i = 1'b0;
        if (guard >= 20000) check("send_timeout", 32'(idx), 32'(s.size()));
    endtask

    task automatic drain();
        for (int g = 0; g < 1000; g++) begin
            @(posedge clk);
            #2;
            if (q_data.size() == 0 && !u_if.m_axis_tvalid_o) break;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", 32'(q_data.size()), 32'd0);
        check("hdr_queue_empty", 32'(q_hdr.size()), 32'd0);
    endtask

    task automatic run_stream(input logic [7:0] s[$], output int nh, output int ne, output int nb);
        got_hdr = 0;
        got_err = 0;
        got_beats = 0;
        model(s, nh, ne);
        nb = q_data.size();
        send(s);
        drain();
    endtask

    initial begin
        logic [7:0] s[$];
        logic [7:0] legal[4];
        int nh, ne, nb, len, gap;
        logic [7:0] op;

        legal = '{8'hEC, 8'hAD, 8'h88, 8'h99};
        vt[0] = '{128'hEC_00_08_00_11_22_33_44, 8, 0, 1, 0, 4, 8'hEC, 16'd4};
        vt[1] = '{128'hAD_00_0C_00_01_02_03_04_05_06_07_08, 12, 1, 1, 0, 8, 8'hAD, 16'd8};
        vt[2] = '{128'h5A_00_06_00_AA_BB_EC_00_05_00_77, 11, 0, 1, 1, 1, 8'hEC, 16'd1};
        vt[3] = '{128'hEC_00_02_00_EC_00_05_00_55, 9, 0, 1, 1, 1, 8'hEC, 16'd1};
        vt[4] = '{128'hEC_00_01_04_99_00_05_00_66, 9, 2, 1, 1, 1, 8'h99, 16'd1};
        vt[5] = '{128'h88_00_04_00, 4, 0, 1, 0, 0, 8'h88, 16'd0};

        rst = 1'b1;
        u_if.s_axis_tvalid_i = 1'b0;
        u_if.s_axis_tdata_i  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 32'(u_if.s_axis_tready_o), 32'd0);
        check("rst_tvalid", 32'(u_if.m_axis_tvalid_o), 32'd0);
        check("rst_tlast",  32'(u_if.m_axis_tlast_o), 32'd0);
        check("rst_hdr",    32'(u_if.hdr_valid_o), 32'd0);
        check("rst_err",    32'(u_if.err_o), 32'd0);
        check("rst_opcode", 32'(u_if.opcode_o), 32'd0);
        check("rst_plen",   32'(u_if.payload_len_o), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_tready", 32'(u_if.s_axis_tready_o), 32'd1);
        mon_en = 1;

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            rdy_mode = vt[v].mode;
            s.delete();
            for (int i = 0; i < vt[v].n; i++)
                s.push_back(vt[v].b[(vt[v].n - 1 - i) * 8 +: 8]);
            run_stream(s, nh, ne, nb);
            check($sformatf("v%0d_hdrs", v),  32'(got_hdr),   32'(vt[v].hdrs));
            check($sformatf("v%0d_errs", v),  32'(got_err),   32'(vt[v].errs));
            check($sformatf("v%0d_beats", v), 32'(got_beats), 32'(vt[v].beats));
            check($sformatf("v%0d_op", v),    32'(u_if.opcode_o), 32'(vt[v].op));
            check($sformatf("v%0d_plen", v),  32'(u_if.payload_len_o), 32'(vt[v].plen));
        end

        // Reset while a payload beat is stalled on m_axis.
        mon_en = 0;
        rdy_mode = 3;
        gaps = 0;
        @(posedge clk);
        #1;
        s = '{8'hEC, 8'h00, 8'h10, 8'h00, 8'h5C};
        send(s);
        @(posedge clk);
        #1;
        check("midpkt_valid",  32'(u_if.m_axis_tvalid_o), 32'd1);
        check("midpkt_data",   32'(u_if.m_axis_tdata_o), 32'h5C);
        check("midpkt_stall",  32'(u_if.s_axis_tready_o), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tvalid", 32'(u_if.m_axis_tvalid_o), 32'd0);
        check("midrst_tdata",  32'(u_if.m_axis_tdata_o), 32'd0);
        check("midrst_opcode", 32'(u_if.opcode_o), 32'd0);
        check("midrst_plen",   32'(u_if.payload_len_o), 32'd0);
        rst = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        mon_en = 1;
        s = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'hDE, 8'hAD};
        run_stream(s, nh, ne, nb);
        check("postrst_hdrs",  32'(got_hdr), 32'd1);
        check("postrst_beats", 32'(got_beats), 32'd2);
        check("postrst_errs",  32'(got_err), 32'd0);

        // Randomized packet stream against the reference.
        gaps = 1;
        rdy_mode = 2;
        s.delete();
        for (int p = 0; p < 40; p++) begin
            op = ($urandom_range(0, 9) < 7) ? legal[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0:       len = $urandom_range(0, 3);
                1:       len = MAXL + $urandom_range(1, 50);
                default: len = $urandom_range(4, 14);
            endcase
            s.push_back(op);
            s.push_back(8'($urandom_range(0, 255)));
            s.push_back(8'(len));
            s.push_back(8'(len >> 8));
            if (len >= 4 && len <= MAXL)
                for (int k = 0; k < len - 4; k++) s.push_back(8'($urandom_range(0, 255)));
        end
        run_stream(s, nh, ne, nb);
        check("rand_hdrs",  32'(got_hdr), 32'(nh));
        check("rand_errs",  32'(got_err), 32'(ne));
        check("rand_beats", 32'(got_beats), 32'(nb));
        gaps = 0;
        rdy_mode = 0;

`ifdef UART_ALU_PARSER_TIMEOUT_EN
        // Idle gap inside a packet: pending beat delivered, err near gap 100.
        got_err = 0;
        got_beats = 0;
        q_data.push_back(8'h11);
        q_last.push_back(1'b0);
        q_hdr.push_back({8'hEC, 16'd4});
        s = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h11};
        send(s);
        gap = 0;
        while (got_err == 0 && gap < 300) begin
            @(posedge clk);
            #1;
            gap++;
        end
        check("tmo_fired", 32'(got_err), 32'd1);
        check("tmo_gap_ok", 32'(gap >= 98 && gap <= 102), 32'd1);
        check("tmo_beat", 32'(got_beats), 32'd1);
        s = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h21, 8'h43};
        run_stream(s, nh, ne, nb);
        check("tmo_next_hdrs",  32'(got_hdr), 32'd1);
        check("tmo_next_beats", 32'(got_beats), 32'd2);
        check("tmo_next_errs",  32'(got_err), 32'd0);
`endif

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
